beethoven_stream_reader: RTL and testbench

//  Read-stream responder: accepts (addr, len) read requests from a core such as

---
 rtl/beethoven_stream_reader_if.sv | 46 ++++
 rtl/beethoven_stream_reader.sv | 180 ++++++++++++++++++
 tb/tb_beethoven_stream_reader.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/beethoven_stream_reader_if.sv
// beethoven_stream_reader_if
//   Bundles the three channels around the stream reader:
//     - request channel from the core (req_*)
//     - beat stream back to the core (data*, inProgress)
//     - memory read address / read data channels (mem_ar_*, mem_r_*)
//   Modports:
//     slave  : the stream reader itself
//     master : the environment (core + memory) driving the reader
interface beethoven_stream_reader_if #(
    parameter int DATA_BYTES = 16,
    parameter int ADDR_W     = 64,
    parameter int LEN_W      = 34
);
    logic                    req_valid;
    logic                    req_ready;
    logic [LEN_W-1:0]        req_len;
    logic [ADDR_W-1:0]       req_addr_address;
    logic                    inProgress;

    logic                    data_valid;
    logic                    data_ready;
    logic [8*DATA_BYTES-1:0] data;

    logic                    mem_ar_valid;
    logic                    mem_ar_ready;
    logic [ADDR_W-1:0]       mem_ar_addr;
    logic [7:0]              mem_ar_len;
    logic                    mem_r_valid;
    logic                    mem_r_ready;
    logic [8*DATA_BYTES-1:0] mem_r_data;
    logic                    mem_r_last;

    modport slave (
        input  req_valid, req_len, req_addr_address, data_ready,
               mem_ar_ready, mem_r_valid, mem_r_data, mem_r_last,
        output req_ready, inProgress, data_valid, data,
               mem_ar_valid, mem_ar_addr, mem_ar_len, mem_r_ready
    );

    modport master (
        output req_valid, req_len, req_addr_address, data_ready,
               mem_ar_ready, mem_r_valid, mem_r_data, mem_r_last,
        input  req_ready, inProgress, data_valid, data,
               mem_ar_valid, mem_ar_addr, mem_ar_len, mem_r_ready
    );
endinterface

// File: rtl/beethoven_stream_reader.sv
// beethoven_stream_reader
//   Accepts one (addr, len) read request at a time, splits it into memory
//   bursts of at most MAX_BURST beats that never cross a 4 KiB page, and
//   streams the returned beats to the core through a FIFO_DEPTH-beat buffer.
//   Bursts are only issued when the buffer has room reserved for every beat,
//   so the memory read-data channel can be permanently ready.
// Ports:
//   clock : clock
//   reset : asynchronous active-high reset
//   bus   : beethoven_stream_reader_if.slave (request, beat stream, memory)
module beethoven_stream_reader #(
    parameter int DATA_BYTES = 16,
    parameter int ADDR_W     = 64,
    parameter int LEN_W      = 34,
    parameter int MAX_BURST  = 16,
    parameter int FIFO_DEPTH = 32
) (
    input logic                       clock,
    input logic                       reset,
    beethoven_stream_reader_if.slave  bus
);
    localparam int OFF_W = $clog2(DATA_BYTES);
    localparam int DW    = 8 * DATA_BYTES;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int MW    = (LEN_W > 13) ? LEN_W : 13;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  beats_to_issue;
    logic [LEN_W-1:0]  beats_to_deliver;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  occupancy;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DW-1:0]     fifo_mem [FIFO_DEPTH];

    logic [12:0]       page_rem;
    logic [12:0]       beats_to_page;
    logic [MW-1:0]     burst_min;
    logic [8:0]        burst_beats;
    logic [MW-1:0]     credit;
    logic              credit_ok;

    logic              req_fire;
    logic              ar_fire;
    logic              push;
    logic              pop;

    assign req_fire = bus.req_valid && bus.req_ready;
    assign ar_fire  = bus.mem_ar_valid && bus.mem_ar_ready;
    assign push     = bus.mem_r_valid;
    assign pop      = bus.data_valid && bus.data_ready;

    // Burst length is the tightest of: burst cap, remaining beats, and beats
    // left before the next 4 KiB page. The buffer credit counts both beats
    // already stored and beats promised by bursts still in flight; it can only
    // grow while a burst waits, so a raised mem_ar_valid never drops.
    always_comb begin
        page_rem      = 13'd4096 - {1'b0, addr_q[11:0]};
        beats_to_page = page_rem >> OFF_W;
        burst_min     = MW'(beats_to_issue);
        if (burst_min > MW'(MAX_BURST)) begin
            burst_min = MW'(MAX_BURST);
        end
        if (burst_min > MW'(beats_to_page)) begin
            burst_min = MW'(beats_to_page);
        end
        burst_beats = 9'(burst_min);
        credit      = MW'(FIFO_DEPTH) - MW'(occupancy) - MW'(outstanding);
        credit_ok   = credit >= MW'(burst_beats);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_fire) begin
                    state_next = ((bus.req_len >> OFF_W) == '0) ? DRAIN : ISSUE;
                end
            end
            ISSUE: begin
                if (ar_fire && (beats_to_issue == LEN_W'(burst_beats))) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Leave on the last pop itself so inProgress drops the
                // very next cycle.
                if ((beats_to_deliver == '0) ||
                    ((beats_to_deliver == LEN_W'(1)) && pop)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q           <= '0;
            beats_to_issue   <= '0;
            beats_to_deliver <= '0;
        end else if (req_fire) begin
            addr_q           <= bus.req_addr_address & ~ADDR_W'(DATA_BYTES - 1);
            beats_to_issue   <= bus.req_len >> OFF_W;
            beats_to_deliver <= bus.req_len >> OFF_W;
        end else begin
            if (ar_fire) begin
                addr_q         <= addr_q + (ADDR_W'(burst_beats) << OFF_W);
                beats_to_issue <= beats_to_issue - LEN_W'(burst_beats);
            end
            if (pop) begin
                beats_to_deliver <= beats_to_deliver - LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            outstanding <= '0;
            occupancy   <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            outstanding <= outstanding
                         + (ar_fire ? CNT_W'(burst_beats) : CNT_W'(0))
                         - (push ? CNT_W'(1) : CNT_W'(0));
            case ({push, pop})
                2'b10:   occupancy <= occupancy + CNT_W'(1);
                2'b01:   occupancy <= occupancy - CNT_W'(1);
                default: occupancy <= occupancy;
            endcase
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus.mem_r_data;
        end
    end

    assign bus.req_ready    = (state == IDLE) && !reset;
    assign bus.inProgress   = (state != IDLE);
    assign bus.mem_ar_valid = (state == ISSUE) && credit_ok;
    assign bus.mem_ar_addr  = addr_q;
    assign bus.mem_ar_len   = 8'(burst_beats - 9'd1);
    assign bus.mem_r_ready  = 1'b1;
    assign bus.data_valid   = (occupancy != '0);
    assign bus.data         = fifo_mem[rd_ptr];

    // Space is reserved before every burst, so a push into a full buffer
    // means the credit accounting is broken.
    overflow_check: assert property (@(posedge clock) disable iff (reset)
        (bus.mem_r_valid && !pop) |-> (occupancy < CNT_W'(FIFO_DEPTH)));

    unexpected_beat_check: assert property (@(posedge clock) disable iff (reset)
        bus.mem_r_valid |-> (outstanding != '0));

    // The final outstanding beat necessarily ends a burst.
    last_beat_check: assert property (@(posedge clock) disable iff (reset)
        (bus.mem_r_valid && (outstanding == CNT_W'(1))) |-> bus.mem_r_last);
endmodule

// File: tb/tb_beethoven_stream_reader.sv
// tb_beethoven_stream_reader
//   Directed bench for beethoven_stream_reader. Stimulus pushes expected
//   memory bursts and expected beats into queues; a single monitor process
//   models memory, pops and compares bursts and beats as they fire, and
//   tracks the expected inProgress / req_ready levels cycle by cycle.
`timescale 1ns/1ps
module tb_beethoven_stream_reader;
    localparam int DATA_BYTES = 16;
    localparam int ADDR_W     = 64;
    localparam int LEN_W      = 34;
    localparam int MAX_BURST  = 16;
    localparam int FIFO_DEPTH = 32;
    localparam int DW         = 8 * DATA_BYTES;

    typedef logic [127:0] val_t;
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
    } ar_t;
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              last;
    } beat_t;

    logic clock;
    logic reset;

    beethoven_stream_reader_if #(
        .DATA_BYTES(DATA_BYTES), .ADDR_W(ADDR_W), .LEN_W(LEN_W)
    ) bus ();

    beethoven_stream_reader #(
        .DATA_BYTES(DATA_BYTES), .ADDR_W(ADDR_W), .LEN_W(LEN_W),
        .MAX_BURST(MAX_BURST), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    logic [DW-1:0] expData[$];
    ar_t           expAr[$];
    beat_t         pending[$];
    int            errors = 0;
    int            checks = 0;
    int            arFires = 0;
    int            dataFires = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [DW-1:0] beatData(input logic [ADDR_W-1:0] a);
        return {a ^ 64'hDEADBEEF0BADF00D, ~a};
    endfunction

    task automatic checkOutput(input string name, input val_t actual, input val_t expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic expectAr(input logic [ADDR_W-1:0] addr, input logic [7:0] len);
        ar_t a;
        a.addr = addr;
        a.len  = len;
        expAr.push_back(a);
    endtask

    // Queue the expected beats, then hold the request until it is accepted.
    task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len);
        logic [ADDR_W-1:0] base;
        int                n;
        base = addr & ~64'hF;
        for (int i = 0; i < int'(len >> 4); i++) begin
            expData.push_back(beatData(base + 64'(i * DATA_BYTES)));
        end
        n = 0;
        @(negedge clock);
        bus.req_valid        = 1'b1;
        bus.req_addr_address = addr;
        bus.req_len          = len;
        #2;
        while (!bus.req_ready && n < 100) begin
            @(negedge clock);
            #2;
            n++;
        end
        checkOutput("req_accept", val_t'(n < 100), val_t'(1));
        @(negedge clock);
        bus.req_valid = 1'b0;
    endtask

    task automatic waitDone(input string name);
        int n;
        n = 0;
        while ((expData.size() != 0 || bus.inProgress) && n < 3000) begin
            @(negedge clock);
            #3;
            n++;
        end
        checkOutput({name, "_done"}, val_t'(n < 3000), val_t'(1));
        checkOutput({name, "_ar_left"}, val_t'(expAr.size()), val_t'(0));
    endtask

    // Memory model + scoreboards + inProgress model, all sampled 2 ns after
    // the falling edge, i.e. exactly what the next rising edge will see.
    initial begin : monitor
        logic              expInProg;
        int                beatsLeft;
        logic              prevArHold;
        logic [ADDR_W-1:0] prevArAddr;
        logic [7:0]        prevArLen;
        logic              prevDataHold;
        logic [DW-1:0]     prevData;
        logic              dataFire;
        ar_t               a;
        logic [DW-1:0]     e;
        expInProg       = 1'b0;
        beatsLeft       = 0;
        prevArHold      = 1'b0;
        prevArAddr      = '0;
        prevArLen       = '0;
        prevDataHold    = 1'b0;
        prevData        = '0;
        bus.mem_r_valid = 1'b0;
        bus.mem_r_data  = '0;
        bus.mem_r_last  = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset && pending.size() != 0) begin
                bus.mem_r_valid = 1'b1;
                bus.mem_r_data  = beatData(pending[0].addr);
                bus.mem_r_last  = pending[0].last;
            end else begin
                bus.mem_r_valid = 1'b0;
                bus.mem_r_data  = '0;
                bus.mem_r_last  = 1'b0;
            end
            #2;
            if (reset) begin
                expData.delete();
                expAr.delete();
                pending.delete();
                expInProg    = 1'b0;
                beatsLeft    = 0;
                prevArHold   = 1'b0;
                prevDataHold = 1'b0;
                checkOutput("rst_req_ready", val_t'(bus.req_ready), val_t'(0));
                checkOutput("rst_data_valid", val_t'(bus.data_valid), val_t'(0));
                checkOutput("rst_ar_valid", val_t'(bus.mem_ar_valid), val_t'(0));
                checkOutput("rst_inProgress", val_t'(bus.inProgress), val_t'(0));
                checkOutput("rst_r_ready", val_t'(bus.mem_r_ready), val_t'(1));
            end else begin
                checkOutput("inProgress", val_t'(bus.inProgress), val_t'(expInProg));
                checkOutput("req_ready", val_t'(bus.req_ready), val_t'(!expInProg));
                checkOutput("r_ready", val_t'(bus.mem_r_ready), val_t'(1));

                if (prevArHold) begin
                    checkOutput("ar_hold_valid", val_t'(bus.mem_ar_valid), val_t'(1));
                    checkOutput("ar_hold_addr", val_t'(bus.mem_ar_addr), val_t'(prevArAddr));
                    checkOutput("ar_hold_len", val_t'(bus.mem_ar_len), val_t'(prevArLen));
                end
                if (bus.mem_ar_valid && bus.mem_ar_ready) begin
                    arFires++;
                    checkOutput("ar_expected", val_t'(expAr.size() != 0), val_t'(1));
                    if (expAr.size() != 0) begin
                        a = expAr.pop_front();
                        checkOutput("ar_addr", val_t'(bus.mem_ar_addr), val_t'(a.addr));
                        checkOutput("ar_len", val_t'(bus.mem_ar_len), val_t'(a.len));
                    end
                end
                prevArHold = bus.mem_ar_valid && !bus.mem_ar_ready;
                prevArAddr = bus.mem_ar_addr;
                prevArLen  = bus.mem_ar_len;

                if (prevDataHold) begin
                    checkOutput("data_hold_valid", val_t'(bus.data_valid), val_t'(1));
                    checkOutput("data_hold_value", val_t'(bus.data), val_t'(prevData));
                end
                dataFire = bus.data_valid && bus.data_ready;
                if (dataFire) begin
                    dataFires++;
                    checkOutput("data_expected", val_t'(expData.size() != 0), val_t'(1));
                    if (expData.size() != 0) begin
                        e = expData.pop_front();
                        checkOutput("data_beat", val_t'(bus.data), val_t'(e));
                    end
                end
                prevDataHold = bus.data_valid && !bus.data_ready;
                prevData     = bus.data;

                if (bus.mem_r_valid && pending.size() != 0) begin
                    void'(pending.pop_front());
                end
                if (bus.mem_ar_valid && bus.mem_ar_ready) begin
                    for (int i = 0; i <= int'(bus.mem_ar_len); i++) begin
                        beat_t b;
                        b.addr = bus.mem_ar_addr + 64'(i * DATA_BYTES);
                        b.last = (i == int'(bus.mem_ar_len));
                        pending.push_back(b);
                    end
                end

                if (bus.req_valid && bus.req_ready) begin
                    expInProg = 1'b1;
                    beatsLeft = int'(bus.req_len >> 4);
                end else begin
                    if (dataFire) begin
                        beatsLeft--;
                    end
                    if (expInProg && beatsLeft == 0) begin
                        expInProg = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin : stimulus
        int base;
        int n;
        reset                = 1'b0;
        bus.req_valid        = 1'b0;
        bus.req_len          = '0;
        bus.req_addr_address = '0;
        bus.data_ready       = 1'b1;
        bus.mem_ar_ready     = 1'b1;
        #1 reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        $display("[TB] single aligned burst");
        expectAr(64'h1000, 8'd15);
        applyStimulus(64'h1000, 34'd256);
        waitDone("t1");

        $display("[TB] request straddling a 4 KiB page");
        expectAr(64'h1F80, 8'd7);
        expectAr(64'h2000, 8'd15);
        expectAr(64'h2100, 8'd7);
        applyStimulus(64'h1F80, 34'd512);
        waitDone("t2");

        $display("[TB] back-pressure limits issue to buffer depth");
        @(negedge clock);
        bus.data_ready = 1'b0;
        expectAr(64'h4000, 8'd15);
        expectAr(64'h4100, 8'd15);
        expectAr(64'h4200, 8'd15);
        expectAr(64'h4300, 8'd15);
        base = arFires;
        applyStimulus(64'h4000, 34'd1024);
        repeat (60) @(negedge clock);
        #3;
        checkOutput("t3_ar_credit_limit", val_t'(arFires - base), val_t'(2));
        checkOutput("t3_data_waiting", val_t'(bus.data_valid), val_t'(1));
        @(negedge clock);
        bus.data_ready = 1'b1;
        waitDone("t3");

        $display("[TB] sub-beat requests");
        base = arFires;
        applyStimulus(64'h5000, 34'd0);
        waitDone("t4a");
        applyStimulus(64'h5010, 34'd15);
        waitDone("t4b");
        checkOutput("t4_no_ar", val_t'(arFires - base), val_t'(0));

        $display("[TB] stalled address channel");
        @(negedge clock);
        bus.mem_ar_ready = 1'b0;
        expectAr(64'h3000, 8'd3);
        applyStimulus(64'h3000, 34'd64);
        repeat (5) @(negedge clock);
        #3;
        checkOutput("t5_ar_waiting", val_t'(bus.mem_ar_valid), val_t'(1));
        checkOutput("t5_ar_addr", val_t'(bus.mem_ar_addr), val_t'(64'h3000));
        @(negedge clock);
        bus.mem_ar_ready = 1'b1;
        waitDone("t5");

        $display("[TB] reset in the middle of a burst");
        expectAr(64'h8000, 8'd15);
        base = dataFires;
        applyStimulus(64'h8000, 34'd256);
        n = 0;
        while ((dataFires - base) < 7 && n < 200) begin
            @(negedge clock);
            #3;
            n++;
        end
        checkOutput("t6_reached_beat7", val_t'(n < 200), val_t'(1));
        @(negedge clock);
        reset = 1'b1;
        #1;
        checkOutput("t6_rst_req_ready", val_t'(bus.req_ready), val_t'(0));
        checkOutput("t6_rst_data_valid", val_t'(bus.data_valid), val_t'(0));
        checkOutput("t6_rst_ar_valid", val_t'(bus.mem_ar_valid), val_t'(0));
        checkOutput("t6_rst_inProgress", val_t'(bus.inProgress), val_t'(0));
        checkOutput("t6_rst_r_ready", val_t'(bus.mem_r_ready), val_t'(1));
        repeat (2) @(negedge clock);
        reset = 1'b0;
        expectAr(64'h9000, 8'd1);
        base = dataFires;
        applyStimulus(64'h9000, 34'd32);
        waitDone("t6");
        checkOutput("t6_two_beats", val_t'(dataFires - base), val_t'(2));

        repeat (3) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
